// File: rtl/ping_pong_ctrl_w_pkg.sv
// Shared types and default sizing for the west ping-pong buffer controller.
package ping_pong_pkg;

    localparam int PP_TOTAL_DEPTH   = 12;
    localparam int PP_TOTAL_MODULES = 4;
    localparam int PP_ADDR_WIDTH    = 8;
    localparam int PP_READ_LAT      = 2;
    localparam int HALF_DEPTH       = PP_TOTAL_DEPTH / 2;
    localparam int READS_PER_BANK   = HALF_DEPTH * PP_TOTAL_MODULES;
    localparam int PP_SLICE_W       = (PP_TOTAL_MODULES > 1) ? $clog2(PP_TOTAL_MODULES) : 1;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_t;

    typedef logic bank_t;

    typedef struct packed {
        logic  valid;
        bank_t bank;
        logic  first;
        logic  last;
    } sa_tag_t;

endpackage

// File: rtl/ping_pong_ctrl_w_if.sv
// Producer handshake, bank port controls and systolic-array tags of the west controller.
interface ping_pong_ctrl_w_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int SLICE_W    = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  rd_go;
    logic [SLICE_W-1:0]    slicing_idx;
    logic                  bank0_ena, bank0_enb, bank0_wea, bank0_web;
    logic [ADDR_WIDTH-1:0] bank0_addra, bank0_addrb;
    logic                  bank1_ena, bank1_enb, bank1_wea, bank1_web;
    logic [ADDR_WIDTH-1:0] bank1_addra, bank1_addrb;
    logic                  sa_valid, sa_bank, sa_first, sa_last;
    logic [1:0]            bank_full;

    modport slave (
        input  in_valid, rd_go,
        output in_ready, slicing_idx,
        output bank0_ena, bank0_enb, bank0_wea, bank0_web, bank0_addra, bank0_addrb,
        output bank1_ena, bank1_enb, bank1_wea, bank1_web, bank1_addra, bank1_addrb,
        output sa_valid, sa_bank, sa_first, sa_last, bank_full
    );

    modport master (
        output in_valid, rd_go,
        input  in_ready, slicing_idx,
        input  bank0_ena, bank0_enb, bank0_wea, bank0_web, bank0_addra, bank0_addrb,
        input  bank1_ena, bank1_enb, bank1_wea, bank1_web, bank1_addra, bank1_addrb,
        input  sa_valid, sa_bank, sa_first, sa_last, bank_full
    );
endinterface

// File: rtl/ping_pong_ctrl_w_read_seq.sv
// Read FSM: walks a full bank slice-inner/row-outer and tags each read through
// a READ_LAT-deep delay line so the tags line up with the buffer's dout.
module pp_read_sequencer
    import ping_pong_pkg::*;
#(
    parameter int TOTAL_DEPTH   = PP_TOTAL_DEPTH,
    parameter int TOTAL_MODULES = PP_TOTAL_MODULES,
    parameter int ADDR_WIDTH    = PP_ADDR_WIDTH,
    parameter int READ_LAT      = PP_READ_LAT,
    parameter int SLICE_W       = PP_SLICE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_go_i,
    input  logic [1:0]            bank_full_i,
    output logic                  rd_en_o,
    output bank_t                 rd_bank_o,
    output logic [ADDR_WIDTH-1:0] rd_r_o,
    output logic [SLICE_W-1:0]    rd_s_o,
    output logic                  release_o,
    output sa_tag_t               sa_tag_o
);
    localparam logic [ADDR_WIDTH-1:0] R_LAST = ADDR_WIDTH'(TOTAL_DEPTH / 2 - 1);
    localparam logic [SLICE_W-1:0]    S_LAST = SLICE_W'(TOTAL_MODULES - 1);

    rd_state_t             state_q, state_d;
    bank_t                 rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0] r_q, r_d;
    logic [SLICE_W-1:0]    s_q, s_d;
    logic                  first_q, first_d;
    logic                  last_s;
    bank_t                 other_bank_s;
    sa_tag_t               tag_s;
    sa_tag_t [READ_LAT-1:0] dl_q;

    // Next-state logic; on the last issue cycle the next bank may start with no idle gap.
    always_comb begin
        state_d      = state_q;
        rd_bank_d    = rd_bank_q;
        r_d          = r_q;
        s_d          = s_q;
        first_d      = 1'b0;
        other_bank_s = ~rd_bank_q;
        last_s       = (state_q == RD_RUN) && (r_q == R_LAST) && (s_q == S_LAST);
        case (state_q)
            RD_IDLE: begin
                if (bank_full_i[rd_bank_q] && rd_go_i) begin
                    state_d = RD_RUN;
                    r_d     = {ADDR_WIDTH{1'b0}};
                    s_d     = {SLICE_W{1'b0}};
                    first_d = 1'b1;
                end else begin
                    state_d = RD_IDLE;
                end
            end
            RD_RUN: begin
                if (last_s) begin
                    rd_bank_d = other_bank_s;
                    r_d       = {ADDR_WIDTH{1'b0}};
                    s_d       = {SLICE_W{1'b0}};
                    if (bank_full_i[other_bank_s] && rd_go_i) begin
                        state_d = RD_RUN;
                        first_d = 1'b1;
                    end else begin
                        state_d = RD_IDLE;
                    end
                end else if (s_q == S_LAST) begin
                    s_d = {SLICE_W{1'b0}};
                    r_d = r_q + ADDR_WIDTH'(1);
                end else begin
                    s_d = s_q + SLICE_W'(1);
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // State, counters and the one-cycle first-beat marker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RD_IDLE;
            rd_bank_q <= 1'b0;
            r_q       <= {ADDR_WIDTH{1'b0}};
            s_q       <= {SLICE_W{1'b0}};
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            r_q       <= r_d;
            s_q       <= s_d;
            first_q   <= first_d;
        end
    end

    assign tag_s = '{valid: (state_q == RD_RUN), bank: rd_bank_q, first: first_q, last: last_s};

    // Tag delay line matching the buffer read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dl_q <= {READ_LAT{4'b0000}};
        end else begin
            dl_q[0] <= tag_s;
            for (int i = 1; i < READ_LAT; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    assign rd_en_o   = (state_q == RD_RUN);
    assign rd_bank_o = rd_bank_q;
    assign rd_r_o    = r_q;
    assign rd_s_o    = s_q;
    assign release_o = last_s;
    assign sa_tag_o  = dl_q[READ_LAT-1];

endmodule

// File: rtl/ping_pong_ctrl_w.sv
// West ping-pong buffer controller: write fill counter, per-bank full flags and
// port A/B muxing between the producer and the read sequencer.
module ping_pong_ctrl_w
    import ping_pong_pkg::*;
#(
    parameter int TOTAL_DEPTH   = PP_TOTAL_DEPTH,
    parameter int TOTAL_MODULES = PP_TOTAL_MODULES,
    parameter int ADDR_WIDTH    = PP_ADDR_WIDTH,
    parameter int READ_LAT      = PP_READ_LAT
) (
    input logic clk,
    input logic rst_n,
    ping_pong_ctrl_w_if.slave bus
);
    localparam int SLICE_W = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1;
    localparam logic [ADDR_WIDTH-1:0] WR_LAST  = ADDR_WIDTH'(TOTAL_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] HALF_OFS = ADDR_WIDTH'(TOTAL_DEPTH / 2);

    bank_t                 wr_bank_q, wr_bank_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic                  in_ready_s, wfire_s, wr_done_s;
    logic [1:0]            set_s, clr_s, wr_sel_s, rd_sel_s;
    logic                  rd_en_s, rd_release_s;
    bank_t                 rd_bank_s;
    logic [ADDR_WIDTH-1:0] rd_r_s, rd_rb_s;
    logic [SLICE_W-1:0]    rd_s_s;
    sa_tag_t               sa_tag_s;

    pp_read_sequencer #(
        .TOTAL_DEPTH  (TOTAL_DEPTH),
        .TOTAL_MODULES(TOTAL_MODULES),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .READ_LAT     (READ_LAT),
        .SLICE_W      (SLICE_W)
    ) u_rd_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_go_i    (bus.rd_go),
        .bank_full_i(bank_full_q),
        .rd_en_o    (rd_en_s),
        .rd_bank_o  (rd_bank_s),
        .rd_r_o     (rd_r_s),
        .rd_s_o     (rd_s_s),
        .release_o  (rd_release_s),
        .sa_tag_o   (sa_tag_s)
    );

    // Write handshake and fill bookkeeping; a release by the reader and a fill by
    // the writer always hit different banks, so set and clear never collide.
    always_comb begin
        in_ready_s = ~bank_full_q[wr_bank_q];
        wfire_s    = bus.in_valid & in_ready_s;
        wr_done_s  = wfire_s && (wr_addr_q == WR_LAST);
        wr_bank_d  = wr_bank_q;
        wr_addr_d  = wr_addr_q;
        if (wr_done_s) begin
            wr_addr_d = {ADDR_WIDTH{1'b0}};
            wr_bank_d = ~wr_bank_q;
        end else if (wfire_s) begin
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        end else begin
            wr_addr_d = wr_addr_q;
        end
        set_s       = {wr_done_s & wr_bank_q, wr_done_s & ~wr_bank_q};
        clr_s       = {rd_release_s & rd_bank_s, rd_release_s & ~rd_bank_s};
        bank_full_d = (bank_full_q | set_s) & ~clr_s;
    end

    // Write pointer and full flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= {ADDR_WIDTH{1'b0}};
            bank_full_q <= 2'b00;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            bank_full_q <= bank_full_d;
        end
    end

    assign wr_sel_s = {wfire_s & wr_bank_q, wfire_s & ~wr_bank_q};
    assign rd_sel_s = {rd_en_s & rd_bank_s, rd_en_s & ~rd_bank_s};
    assign rd_rb_s  = rd_r_s + HALF_OFS;

    assign bus.in_ready    = in_ready_s;
    assign bus.slicing_idx = rd_s_s;
    assign bus.bank_full   = bank_full_q;

    assign bus.bank0_ena   = wr_sel_s[0] | rd_sel_s[0];
    assign bus.bank0_enb   = rd_sel_s[0];
    assign bus.bank0_wea   = wr_sel_s[0];
    assign bus.bank0_web   = 1'b0;
    assign bus.bank0_addra = wr_sel_s[0] ? wr_addr_q : (rd_sel_s[0] ? rd_r_s : {ADDR_WIDTH{1'b0}});
    assign bus.bank0_addrb = rd_sel_s[0] ? rd_rb_s : {ADDR_WIDTH{1'b0}};

    assign bus.bank1_ena   = wr_sel_s[1] | rd_sel_s[1];
    assign bus.bank1_enb   = rd_sel_s[1];
    assign bus.bank1_wea   = wr_sel_s[1];
    assign bus.bank1_web   = 1'b0;
    assign bus.bank1_addra = wr_sel_s[1] ? wr_addr_q : (rd_sel_s[1] ? rd_r_s : {ADDR_WIDTH{1'b0}});
    assign bus.bank1_addrb = rd_sel_s[1] ? rd_rb_s : {ADDR_WIDTH{1'b0}};

    assign bus.sa_valid = sa_tag_s.valid;
    assign bus.sa_bank  = sa_tag_s.bank;
    assign bus.sa_first = sa_tag_s.first;
    assign bus.sa_last  = sa_tag_s.last;

endmodule

// File: tb/tb_ping_pong_ctrl_w.sv
// Scoreboard bench for ping_pong_ctrl_w: the driver predicts writes and whole-bank
// read sequences, a negedge monitor pops and compares them as the DUT presents them.
module tb_ping_pong_ctrl_w;
    localparam int D   = 12;
    localparam int M   = 4;
    localparam int H   = D / 2;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ping_pong_ctrl_w_if #(.ADDR_WIDTH(8), .SLICE_W(2)) bus ();

    ping_pong_ctrl_w #(
        .TOTAL_DEPTH(D), .TOTAL_MODULES(M), .ADDR_WIDTH(8), .READ_LAT(LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int exp_wq[$];
    int exp_iq[$];
    int exp_sq[$];
    int iss_cyc[$];
    int n_acc = 0, filled = 0, reads_done = 0;
    bit exp_ready = 1'b1;
    bit mon_en = 1'b0;
    int cyc = 0;
    int last_iss_cyc = -1000;
    int last_gap = 0;
    int bank_iss_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-bank read order: row outer, slice inner; addrb is the upper half.
    task automatic push_bank_reads(input int bank);
        for (int r = 0; r < H; r++) begin
            for (int s = 0; s < M; s++) begin
                exp_iq.push_back((bank << 24) | (r << 16) | ((r + H) << 8) | s);
                exp_sq.push_back(bank * 4 + ((r == 0 && s == 0) ? 2 : 0)
                                 + ((r == H - 1 && s == M - 1) ? 1 : 0));
            end
        end
    endtask

    task automatic model_clear();
        exp_wq.delete(); exp_iq.delete(); exp_sq.delete(); iss_cyc.delete();
        n_acc = 0; filled = 0; reads_done = 0; bank_iss_cnt = 0;
        last_iss_cyc = -1000; exp_ready = 1'b1;
    endtask

    task automatic step(input bit v, input bit g);
        @(posedge clk);
        #1;
        exp_ready   = (filled - reads_done) < 2;
        bus.in_valid = v;
        bus.rd_go    = g;
        if (v && exp_ready) begin
            exp_wq.push_back(((n_acc / D) % 2) * 256 + (n_acc % D));
            n_acc++;
            if (n_acc % D == 0) begin
                push_bank_reads(filled % 2);
                filled++;
            end
        end
    endtask

    task automatic drain(input int max_cyc);
        int cnt = 0;
        while ((exp_iq.size() != 0 || exp_sq.size() != 0 || exp_wq.size() != 0) && cnt < max_cyc) begin
            step(1'b0, 1'b1);
            cnt++;
        end
        chk("drain_timeout", (exp_iq.size() + exp_sq.size() + exp_wq.size()), 0);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_ctl"}, {bus.bank0_ena, bus.bank0_enb, bus.bank0_wea, bus.bank0_web,
                            bus.bank1_ena, bus.bank1_enb, bus.bank1_wea, bus.bank1_web}, 0);
        chk({tag, "_addr"}, bus.bank0_addra | bus.bank0_addrb | bus.bank1_addra | bus.bank1_addrb, 0);
        chk({tag, "_sa"}, {bus.sa_valid, bus.sa_bank, bus.sa_first, bus.sa_last}, 0);
        chk({tag, "_bank_full"}, bus.bank_full, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_slicing_idx"}, bus.slicing_idx, 0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [1:0] wea, ena, enb, web;
        logic [7:0] addra [2];
        logic [7:0] addrb [2];
        int e, eb, er, ers, es;
        cyc++;
        if (mon_en && rst_n) begin
            wea = {bus.bank1_wea, bus.bank0_wea};
            web = {bus.bank1_web, bus.bank0_web};
            ena = {bus.bank1_ena, bus.bank0_ena};
            enb = {bus.bank1_enb, bus.bank0_enb};
            addra[0] = bus.bank0_addra; addra[1] = bus.bank1_addra;
            addrb[0] = bus.bank0_addrb; addrb[1] = bus.bank1_addrb;
            chk("in_ready", bus.in_ready, exp_ready);
            chk("web_zero", web, 0);
            for (int b = 0; b < 2; b++) begin
                if (wea[b]) begin
                    if (exp_wq.size() == 0) begin
                        chk("write_unexpected", 1, 0);
                    end else begin
                        e = exp_wq.pop_front();
                        chk("wr_bank", b, e / 256);
                        chk("wr_addr", addra[b], e % 256);
                    end
                    chk("wr_bank_not_read", enb[b], 0);
                    chk("wr_ena", ena[b], 1);
                end
                if (enb[b]) begin
                    chk("rd_ena", ena[b], 1);
                    chk("rd_no_wea", wea[b], 0);
                    if (exp_iq.size() == 0) begin
                        chk("read_unexpected", 1, 0);
                    end else begin
                        e   = exp_iq.pop_front();
                        eb  = (e >> 24) & 255; er = (e >> 16) & 255;
                        ers = (e >> 8) & 255;  es = e & 255;
                        chk("rd_bank", b, eb);
                        chk("rd_addra", addra[b], er);
                        chk("rd_addrb", addrb[b], ers);
                        chk("rd_slice", bus.slicing_idx, es);
                        iss_cyc.push_back(cyc);
                        if (er == 0 && es == 0) last_gap = cyc - last_iss_cyc;
                        bank_iss_cnt++;
                        if (er == H - 1 && es == M - 1) begin
                            reads_done++;
                            last_iss_cyc = cyc;
                            bank_iss_cnt = 0;
                        end
                    end
                end
                if (ena[b] && !wea[b] && !enb[b]) chk("stray_ena", b + 10, -1);
            end
            if (bus.sa_valid) begin
                if (exp_sq.size() == 0 || iss_cyc.size() == 0) begin
                    chk("sa_unexpected", 1, 0);
                end else begin
                    e = exp_sq.pop_front();
                    chk("sa_bank", bus.sa_bank, e / 4);
                    chk("sa_first", bus.sa_first, (e / 2) % 2);
                    chk("sa_last", bus.sa_last, e % 2);
                    chk("sa_latency", cyc - iss_cyc.pop_front(), LAT);
                end
            end
        end
    end

    initial begin
        int guard;
        bus.in_valid = 1'b0;
        bus.rd_go    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        model_clear();
        mon_en = 1'b1;
        check_idle("reset");

        // Basic fill of bank 0.
        repeat (D) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        @(negedge clk);
        chk("fill_bank_full", bus.bank_full, 1);
        chk("fill_in_ready", bus.in_ready, 1);

        // Single bank read.
        drain(200);
        step(1'b0, 1'b0);
        @(negedge clk);
        chk("read_bank_full", bus.bank_full, 0);

        // Overlap and backpressure: both banks full, then back-to-back reads.
        repeat (2 * D) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        @(negedge clk);
        chk("both_full", bus.bank_full, 3);
        chk("both_full_in_ready", bus.in_ready, 0);
        drain(300);
        chk("b2b_gap", last_gap, 1);

        // Concurrent random traffic.
        for (int i = 0; i < 800; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        drain(300);

        // Gapped writes.
        for (int i = 0; i < 4 * D; i++) step(1'(i % 2), 1'b1);
        drain(300);

        // Mid-operation reset on the 10th read of a bank.
        guard = 0;
        while (!(n_acc % D == 0 && filled > reads_done) && guard < 100) begin
            step(1'b1, 1'b0);
            guard++;
        end
        chk("reset_fill_timeout", (guard < 100) ? 1 : 0, 1);
        guard = 0;
        while (bank_iss_cnt < 9 && guard < 100) begin
            step(1'b0, 1'b1);
            guard++;
        end
        chk("reset_read_timeout", bank_iss_cnt, 9);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.rd_go    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        check_idle("midreset");
        repeat (3) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        @(negedge clk);
        chk("final_wq_empty", exp_wq.size(), 0);
        chk("final_iq_empty", exp_iq.size(), 0);
        chk("final_sq_empty", exp_sq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ping_pong_ctrl_w.md
Name: ping_pong_ctrl_w

Overview:
- Controller for the west ping-pong buffer. It generates all bank enables, write enables, addresses and slicing_idx.
- Write side: accepts a valid/ready word stream from the linear projection and fills one bank through port A.
- Read side: concurrently streams the other, full bank to the systolic array through ports A and B, stepping slicing_idx.
- The bank roles swap automatically. It sits beside the west buffer wrapper and connects directly to its w_* control inputs.

Parameters:
- TOTAL_DEPTH, 12, words written per bank (addresses 0..TOTAL_DEPTH-1). Must be even.
- TOTAL_MODULES, 4, slicing_idx range 0..TOTAL_MODULES-1.
- ADDR_WIDTH, 8, bank address width. Must satisfy ADDR_WIDTH >= $clog2(TOTAL_DEPTH).
- READ_LAT, 2, cycles from a read enable to valid douta/doutb at the buffer output.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  producer word valid. Data goes directly to bank din.
- in_ready  out  1  controller can accept a word this cycle.
- rd_go  in  1  systolic array may start consuming a bank (level-sensitive).
- slicing_idx  out  $clog2(TOTAL_MODULES)  module slice select.
- bank0_ena, bank0_enb, bank0_wea, bank0_web  out  1 each  bank 0 port controls.
- bank0_addra, bank0_addrb  out  ADDR_WIDTH  bank 0 addresses.
- bank1_ena, bank1_enb, bank1_wea, bank1_web  out  1 each  bank 1 port controls.
- bank1_addra, bank1_addrb  out  ADDR_WIDTH  bank 1 addresses.
- sa_valid  out  1  buffer douta/doutb valid this cycle.
- sa_bank  out  1  bank whose dout is valid.
- sa_first, sa_last  out  1  first/last beat of a bank read.
- bank_full  out  2  per-bank full flags (status).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - wr_bank=0, rd_bank=0, bank_full=00, all counters 0, read FSM in RD_IDLE, delay line cleared.
  - All ena/enb/wea/web/sa_* outputs 0; slicing_idx=0; addresses 0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards the partial fill and the read in progress. Nothing is flushed.
- Write side (combinational controls, so producer data aligns with wea):
  - in_ready = !bank_full[wr_bank].
  - wfire = in_valid & in_ready.
  - On wfire: bank[wr_bank]_ena=1, wea=1, addra=wr_addr.
  - wr_addr increments on each wfire.
  - At wr_addr==TOTAL_DEPTH-1 with wfire: wr_addr wraps to 0, bank_full[wr_bank] sets, wr_bank toggles.
  - web is always 0 on both banks.
- Read FSM, states RD_IDLE and RD_RUN (controls registered):
  - RD_IDLE -> RD_RUN when bank_full[rd_bank] & rd_go. Controls appear the following cycle.
  - RD_RUN issues one read per cycle with no stalls. rd_go is ignored once running.
  - Read enables: bank[rd_bank]_ena=1, enb=1, wea=0.
  - Read addresses: addra=r, addrb=r+TOTAL_DEPTH/2, slicing_idx=s.
  - Loop order: s is the inner loop (0..TOTAL_MODULES-1), r is the outer loop (0..TOTAL_DEPTH/2-1).
  - Reads per bank: TOTAL_DEPTH/2*TOTAL_MODULES.
  - On the last issue cycle:
    - bank_full[rd_bank] clears.
    - rd_bank toggles.
    - The FSM goes to RD_IDLE. If the other bank is full and rd_go=1, it goes back to RD_RUN with no gap.
- Read output tagging:
  - sa_valid/sa_bank/sa_first/sa_last come from a READ_LAT-deep delay line on the issued read.
  - The first read issued after RD_IDLE -> RD_RUN is tagged first; the final read issued on the last issue cycle is tagged last.
- Port mux: when both sides target different banks in the same cycle, each bank's port A is driven by its own owner. The owner is the write side for wr_bank and the read side for rd_bank.
- Same-bank access is impossible by construction: the reader only runs on a full bank, and the writer stalls on a full bank.
- Simultaneous events on the same cycle:
  - A write completing bank X while the reader releases bank Y is legal: both flag updates apply.
  - If the writer's next bank is released that cycle, in_ready rises the next cycle, not the same cycle.
- Both banks full: in_ready=0 until the reader releases one.

Decomposition:
- Package ping_pong_pkg:
  - rd_state_t enum {RD_IDLE, RD_RUN}.
  - bank_t (1 bit).
  - Localparams: HALF_DEPTH = TOTAL_DEPTH/2, and READS_PER_BANK.
- Sub-module pp_read_sequencer: read FSM plus the r/s counters and the delay line.
- Top module: write counter, full flags and port muxing.

Test Plan:
- Basic fill: reset, then 12 consecutive in_valid.
  - wea pulses on bank0 with addra 0..11.
  - After the 12th word: bank_full=01, wr_bank=1, in_ready stays 1.
- Single bank read: fill bank0, hold rd_go=1.
  - 24 read cycles: (addra, addrb, slicing_idx) = (0,6,0),(0,6,1)..(5,11,3).
  - sa_valid spans 24 cycles, starting READ_LAT cycles after the first ena.
  - sa_first on beat 0, sa_last on beat 23, sa_bank=0.
- Overlap and backpressure: fill bank0, rd_go=0, fill bank1.
  - bank_full=11, in_ready=0.
  - Assert rd_go: after bank0's last issue, in_ready=1 the next cycle.
  - Bank1 read follows bank0's with zero idle cycles.
- Concurrent operation: stream writes into bank1 while bank0 is read.
  - No cycle has the same bank with both wea=1 and a read enable.
  - wea and web are never 1 on a reading bank.
- Mid-operation reset: rst_n=0 for 1 cycle during the 10th read of bank0.
  - Next cycle: all controls 0, bank_full=00, sa_valid=0, in_ready=1, wr_addr restarts at 0.
- Gapped writes: toggle in_valid every other cycle.
  - addra advances only on wfire.
  - Bank completes after exactly 12 accepted words.
